// File: rtl/row_pe_gen.sv
`default_nettype none
// ============================================================================
// Module   : row_pe_gen
// Purpose  : Row-wise 1-D convolution PE producing "same"-size rows with edge
//            padding. Define ROW_PE_EDGE_REPLICATE_EN for replicate padding
//            (default build pads both row edges with zero).
// Revision : 1.0  initial release
// ============================================================================
module row_pe_gen #(
  parameter int                          DATA_W     = 8,
  parameter int                          KERNEL_W   = 3,
  parameter int                          COEFF_W    = 5,
  parameter logic [KERNEL_W*COEFF_W-1:0] WEIGHTS    = 15'h0441,
  parameter int                          NORM_SHIFT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vld,
  input  logic              i_eor,
  input  logic              i_eof,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_rdy,
  output logic              o_vld,
  output logic              o_eor,
  output logic              o_eof,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_rdy
);

  localparam int c_H  = (KERNEL_W - 1) / 2;
  localparam int c_AW = DATA_W + COEFF_W + $clog2(KERNEL_W) + 1;
  localparam int c_CW = $clog2(c_H + 2) + 1;
  localparam int c_FW = (c_H > 1) ? $clog2(c_H) : 1;
  localparam logic signed [c_AW-1:0] c_SMAX = c_AW'((1 << DATA_W) - 1);
  localparam logic [c_CW-1:0]        c_EMIT = c_CW'(c_H + 1);

  typedef enum logic [1:0] {
    S_START  = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input skid buffer
  // --------------------------------------------------------------------------
  logic              r_sk_full;
  logic              r_sk_eor;
  logic              r_sk_eof;
  logic [DATA_W-1:0] r_sk_data;
  logic              r_rdy;

  logic              w_adv;
  logic              w_in_acc;
  logic              w_src_vld;
  logic              w_src_eor;
  logic              w_src_eof;
  logic [DATA_W-1:0] w_src_data;
  logic              w_take;
  logic              w_sk_full_nxt;

  state_t r_state;

  // The whole PE moves only when the output register can be overwritten.
  assign w_adv      = !o_vld || i_rdy;
  assign w_in_acc   = i_vld && r_rdy;
  assign w_src_vld  = r_sk_full || w_in_acc;
  assign w_src_data = r_sk_full ? r_sk_data : i_data;
  assign w_src_eor  = r_sk_full ? r_sk_eor  : i_eor;
  assign w_src_eof  = r_sk_full ? r_sk_eof  : i_eof;
  assign w_take     = w_src_vld && w_adv && (r_state != S_FLUSH);

  assign w_sk_full_nxt = r_sk_full ? !w_take : (w_in_acc && !w_take);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sk_full <= 1'b0;
      r_sk_eor  <= 1'b0;
      r_sk_eof  <= 1'b0;
      r_sk_data <= '0;
      r_rdy     <= 1'b0;
    end else begin
      r_sk_full <= w_sk_full_nxt;
      r_rdy     <= !w_sk_full_nxt;
      if (!r_sk_full && w_in_acc && !w_take) begin
        r_sk_eor  <= i_eor;
        r_sk_eof  <= i_eof;
        r_sk_data <= i_data;
      end
    end
  end

  assign o_rdy = r_rdy;

  // --------------------------------------------------------------------------
  // Edge padding values
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] w_lpad;
  logic [DATA_W-1:0] w_rpad;

`ifdef ROW_PE_EDGE_REPLICATE_EN
  logic [DATA_W-1:0] r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= '0;
    end else if (w_take && w_src_eor) begin
      r_last <= w_src_data;
    end
  end

  assign w_lpad = w_src_data;
  assign w_rpad = r_last;
`else
  assign w_lpad = '0;
  assign w_rpad = '0;
`endif

  // --------------------------------------------------------------------------
  // Row FSM and window
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_win [KERNEL_W];
  logic [c_CW-1:0]   r_cnt;
  logic [c_FW-1:0]   r_fcnt;
  logic              r_row_eof;
  logic              r_b_vld;
  logic              r_b_eor;
  logic              r_b_eof;
  logic [c_CW-1:0]   w_cnt_inc;

  // The beat count only has to reach H+1, so it saturates there.
  assign w_cnt_inc = (r_cnt >= c_EMIT) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_START;
      r_cnt     <= '0;
      r_fcnt    <= '0;
      r_row_eof <= 1'b0;
      r_b_vld   <= 1'b0;
      r_b_eor   <= 1'b0;
      r_b_eof   <= 1'b0;
      for (int j = 0; j < KERNEL_W; j++) begin
        r_win[j] <= '0;
      end
    end else if (w_adv) begin
      r_b_vld <= 1'b0;
      r_b_eor <= 1'b0;
      r_b_eof <= 1'b0;
      case (r_state)
        S_START, S_STREAM: begin
          if (w_take) begin
            r_win[0] <= w_src_data;
            if (r_state == S_START) begin
              for (int j = 1; j < KERNEL_W; j++) begin
                r_win[j] <= w_lpad;
              end
              r_cnt   <= c_CW'(1);
              r_b_vld <= (c_H == 0);
            end else begin
              for (int j = 1; j < KERNEL_W; j++) begin
                r_win[j] <= r_win[j-1];
              end
              r_cnt   <= w_cnt_inc;
              r_b_vld <= (w_cnt_inc >= c_EMIT);
            end
            r_state <= S_STREAM;
            if (w_src_eor) begin
              if (c_H == 0) begin
                r_state <= S_START;
                r_b_eor <= 1'b1;
                r_b_eof <= w_src_eof;
              end else begin
                r_state   <= S_FLUSH;
                r_fcnt    <= '0;
                r_row_eof <= w_src_eof;
              end
            end
          end
        end
        S_FLUSH: begin
          r_win[0] <= w_rpad;
          for (int j = 1; j < KERNEL_W; j++) begin
            r_win[j] <= r_win[j-1];
          end
          r_cnt   <= w_cnt_inc;
          r_b_vld <= (w_cnt_inc >= c_EMIT);
          r_fcnt  <= r_fcnt + 1'b1;
          if (r_fcnt == c_FW'(c_H - 1)) begin
            r_state <= S_START;
            r_b_eor <= 1'b1;
            r_b_eof <= r_row_eof;
          end
        end
        default: r_state <= S_START;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: per-tap products (pixels zero-extended, coefficients signed)
  // --------------------------------------------------------------------------
  logic signed [c_AW-1:0] w_prod [KERNEL_W];
  logic signed [c_AW-1:0] r_prod [KERNEL_W];
  logic                   r_v1;
  logic                   r_e1;
  logic                   r_f1;

  for (genvar j = 0; j < KERNEL_W; j++) begin : g_tap
    localparam logic signed [COEFF_W-1:0] c_W  = WEIGHTS[j*COEFF_W +: COEFF_W];
    localparam logic signed [c_AW-1:0]    c_WX = c_AW'(c_W);
    assign w_prod[j] = $signed({{(c_AW-DATA_W){1'b0}}, r_win[j]}) * c_WX;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1 <= 1'b0;
      r_e1 <= 1'b0;
      r_f1 <= 1'b0;
      for (int j = 0; j < KERNEL_W; j++) begin
        r_prod[j] <= '0;
      end
    end else if (w_adv) begin
      r_v1 <= r_b_vld;
      r_e1 <= r_b_eor;
      r_f1 <= r_b_eof;
      for (int j = 0; j < KERNEL_W; j++) begin
        r_prod[j] <= w_prod[j];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: accumulate
  // --------------------------------------------------------------------------
  logic signed [c_AW-1:0] w_acc;
  logic signed [c_AW-1:0] r_sum;
  logic                   r_v2;
  logic                   r_e2;
  logic                   r_f2;

  always_comb begin
    w_acc = '0;
    for (int j = 0; j < KERNEL_W; j++) begin
      w_acc = w_acc + r_prod[j];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum <= '0;
      r_v2  <= 1'b0;
      r_e2  <= 1'b0;
      r_f2  <= 1'b0;
    end else if (w_adv) begin
      r_sum <= w_acc;
      r_v2  <= r_v1;
      r_e2  <= r_e1;
      r_f2  <= r_f1;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: normalise (floor via arithmetic shift), saturate, output
  // --------------------------------------------------------------------------
  logic signed [c_AW-1:0] w_shf;
  logic [DATA_W-1:0]      w_sat;
  logic                   r_o_vld;
  logic                   r_o_eor;
  logic                   r_o_eof;
  logic [DATA_W-1:0]      r_o_data;

  always_comb begin
    w_shf = r_sum >>> NORM_SHIFT;
    if (w_shf[c_AW-1]) begin
      w_sat = '0;
    end else if (w_shf > c_SMAX) begin
      w_sat = c_SMAX[DATA_W-1:0];
    end else begin
      w_sat = w_shf[DATA_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_o_vld  <= 1'b0;
      r_o_eor  <= 1'b0;
      r_o_eof  <= 1'b0;
      r_o_data <= '0;
    end else if (w_adv) begin
      r_o_vld  <= r_v2;
      r_o_eor  <= r_e2;
      r_o_eof  <= r_f2;
      r_o_data <= w_sat;
    end
  end

  assign o_vld  = r_o_vld;
  assign o_eor  = r_o_eor;
  assign o_eof  = r_o_eof;
  assign o_data = r_o_data;

endmodule
`default_nettype wire

// File: tb/tb_row_pe_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_row_pe_gen
// Purpose  : Directed self-checking bench for row_pe_gen ({1,2,1}/4 instance
//            plus a {-1,4,-1}/2 instance for saturation).
// Revision : 1.0  initial release
// ============================================================================
module tb_row_pe_gen;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       vld  = 1'b0;
  logic       eor  = 1'b0;
  logic       eof  = 1'b0;
  logic       rdy  = 1'b1;
  logic [7:0] data = '0;

  logic       a_rdy, a_vld, a_eor, a_eof;
  logic [7:0] a_data;
  logic       b_rdy, b_vld, b_eor, b_eof;
  logic [7:0] b_data;

  int n_cmp = 0;
  int n_bad = 0;
  int hold_chk = 0;
  int hold_bad = 0;

  logic [9:0] qa[$];
  logic [9:0] qb[$];
  logic       a_stall = 1'b0;
  logic [9:0] a_prev  = '0;

  int px[64];
  int exp_d[64];

  always #5 clk = ~clk;

  row_pe_gen u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_eor(eor), .i_eof(eof), .i_data(data),
    .o_rdy(a_rdy), .o_vld(a_vld), .o_eor(a_eor), .o_eof(a_eof), .o_data(a_data),
    .i_rdy(rdy)
  );

  row_pe_gen #(.WEIGHTS(15'h7C9F), .NORM_SHIFT(1)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_vld(vld), .i_eor(eor), .i_eof(eof), .i_data(data),
    .o_rdy(b_rdy), .o_vld(b_vld), .o_eor(b_eor), .o_eof(b_eof), .o_data(b_data),
    .i_rdy(rdy)
  );

  // Output monitor: transfers are collected, and held outputs are checked for stability.
  always @(negedge clk) begin
    if (a_stall) begin
      hold_chk++;
      if ({a_vld, a_eor, a_eof, a_data} !== {1'b1, a_prev}) hold_bad++;
    end
    a_stall = a_vld && !rdy;
    a_prev  = {a_eor, a_eof, a_data};
    if (a_vld && rdy) qa.push_back({a_eor, a_eof, a_data});
    if (b_vld && rdy) qb.push_back({b_eor, b_eof, b_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic send(input int d, input logic e, input logic f);
    int t;
    data = d[7:0];
    eor  = e;
    eof  = f;
    vld  = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (a_rdy) break;
    end
    if (t == 200) chk("send_timeout", a_rdy, 1);
    @(posedge clk);
    #1;
    vld = 1'b0;
    eor = 1'b0;
    eof = 1'b0;
  endtask

  task automatic drain();
    rdy = 1'b1;
    repeat (15) @(posedge clk);
    #1;
  endtask

  task automatic check_q(input string tag, input bit use_b, input int n, input logic last_eof);
    logic [9:0] e;
    int sz;
    sz = use_b ? qb.size() : qa.size();
    chk({tag, "_count"}, sz, n);
    for (int i = 0; i < n; i++) begin
      if (i < sz) begin
        e = use_b ? qb[i] : qa[i];
        chk($sformatf("%s_data%0d", tag, i), {24'd0, e[7:0]}, exp_d[i]);
        chk($sformatf("%s_eor%0d", tag, i), {31'd0, e[9]}, (i == n - 1) ? 1 : 0);
        chk($sformatf("%s_eof%0d", tag, i), {31'd0, e[8]}, (i == n - 1) ? {31'd0, last_eof} : 0);
      end
    end
  endtask

  function automatic int padpx(int n, int len);
    if (n >= 0 && n < len) return px[n];
`ifdef ROW_PE_EDGE_REPLICATE_EN
    return (n < 0) ? px[0] : px[len-1];
`else
    return 0;
`endif
  endfunction

  // Reference for the {1,2,1}/4 kernel: o[k] = sat(floor(sum W_j p(k+1-j) / 4)).
  function automatic int golden(int k, int len);
    int s;
    s = padpx(k + 1, len) + 2 * padpx(k, len) + padpx(k - 1, len);
    s = s >>> 2;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic row4();
    send(4, 0, 0);
    send(8, 0, 0);
    send(12, 0, 0);
    send(16, 1, 0);
  endtask

  task automatic set_row4_exp();
`ifdef ROW_PE_EDGE_REPLICATE_EN
    exp_d[0] = 5; exp_d[1] = 8; exp_d[2] = 12; exp_d[3] = 15;
`else
    exp_d[0] = 4; exp_d[1] = 8; exp_d[2] = 12; exp_d[3] = 11;
`endif
  endtask

  initial begin
    int cyc;
    bit done;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_vld",  a_vld,  0);
    chk("rst_o_eor",  a_eor,  0);
    chk("rst_o_eof",  a_eof,  0);
    chk("rst_o_data", a_data, 0);
    chk("rst_o_rdy",  a_rdy,  0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_o_rdy", a_rdy, 1);
    @(posedge clk);
    #1;

    // Row [4,8,12,16]
    qa.delete(); qb.delete();
    row4();
    drain();
    set_row4_exp();
    check_q("row4", 1'b0, 4, 1'b0);

    // Single-pixel row with eor+eof
    qa.delete(); qb.delete();
    send(100, 1, 1);
    drain();
`ifdef ROW_PE_EDGE_REPLICATE_EN
    exp_d[0] = 100;
`else
    exp_d[0] = 50;
`endif
    check_q("single", 1'b0, 1, 1'b1);

    // Saturation at both bounds with {-1,4,-1}/2
    qa.delete(); qb.delete();
    send(0, 0, 0);
    send(255, 0, 0);
    send(0, 1, 0);
    drain();
    exp_d[0] = 0; exp_d[1] = 255; exp_d[2] = 0;
    check_q("sat", 1'b1, 3, 1'b0);

    // 32-pixel ramp with input gaps and downstream back-pressure
    for (int i = 0; i < 32; i++) px[i] = i * 8 + 5;
    qa.delete(); qb.delete();
    hold_chk = 0;
    hold_bad = 0;
    done = 1'b0;
    cyc  = 0;
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send(px[i], (i == 31), 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          cyc++;
          rdy = ((cyc % 20) >= 15) ? 1'b0 : ((cyc % 2) == 0);
        end
        rdy = 1'b1;
      end
    join
    drain();
    drain();
    for (int k = 0; k < 32; k++) exp_d[k] = golden(k, 32);
    check_q("ramp", 1'b0, 32, 1'b0);
    chk("ramp_hold_seen", {31'd0, (hold_chk > 0)}, 1);
    chk("ramp_hold_stable", hold_bad, 0);

    // eof without eor mid-row is ignored
    px[0] = 10; px[1] = 20; px[2] = 30; px[3] = 40;
    qa.delete(); qb.delete();
    send(10, 0, 0);
    send(20, 0, 1);
    send(30, 0, 0);
    send(40, 1, 0);
    drain();
    for (int k = 0; k < 4; k++) exp_d[k] = golden(k, 4);
    check_q("eof_no_eor", 1'b0, 4, 1'b0);

    // Reset in the middle of a row
    send(4, 0, 0);
    send(8, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_o_vld", a_vld, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    qa.delete(); qb.delete();
    row4();
    drain();
    set_row4_exp();
    check_q("after_rst", 1'b0, 4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/row_pe_gen.md
# row_pe_gen

Parametrised row-wise (horizontal) 1-D convolution processing element with kernel width, data width, coefficient width and normalisation set by parameters. It produces one output pixel per input pixel per row ("same" size) by padding both row edges. It sits in the separable-convolution datapath, feeding the column stage, and uses the same valid/ready + end-of-row/end-of-file stream protocol on both sides.

## Interface
- DATA_W, 8: unsigned pixel width.
- KERNEL_W, 3: taps. Odd, 1..15. H = (KERNEL_W-1)/2.
- COEFF_W, 5: signed coefficient width.
- WEIGHTS, 15'h0441: packed signed coefficients. Tap j is WEIGHTS[j*COEFF_W +: COEFF_W]. Default is {1,2,1}.
- NORM_SHIFT, 2: arithmetic right shift applied to the accumulated sum.

Ports:
- i_clk  in  1  clock. Single clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_vld  in  1  input pixel valid.
- i_eor  in  1  last pixel of row.
- i_eof  in  1  last pixel of frame. Honoured only together with i_eor.
- i_data  in  DATA_W  input pixel.
- o_rdy  out  1  PE can accept input. Registered.
- o_vld  out  1  output pixel valid.
- o_eor  out  1  marks the last output of a row.
- o_eof  out  1  marks the last output of a frame.
- o_data  out  DATA_W  convolved, saturated pixel.
- i_rdy  in  1  downstream ready.

## Operation
- Input path: a 1-entry skid buffer on input, carrying {eor, eof, data}.
  - Passes through combinationally when empty.
  - o_rdy = buffer empty.
- Window: shift register of KERNEL_W entries. Entry 0 is the newest; entry H is the centre.
- Output definition: o[k] = sat(floor((Σ_j W_j·p(k+H−j)) / 2^NORM_SHIFT)).
  - p(n) = x[n] for 0 ≤ n < N, otherwise the pad value (see Configuration).
  - sat clamps to [0, 2^DATA_W−1].
- Accumulator: signed, width DATA_W+COEFF_W+$clog2(KERNEL_W)+1. Pixels are zero-extended before multiplication. No overflow is possible.
- FSM:
  - START: the first accepted pixel of a row loads window entries 1..KERNEL_W−1 with the left pad and entry 0 with x0. Beat count := 1. Go to STREAM, or to FLUSH if eor is set.
  - STREAM: each accepted pixel shifts in, count+1. Go to FLUSH on eor.
  - FLUSH: H beats shift in the right pad. No input is accepted (skid buffer may capture one pixel). After the last pad beat, go to START. If H = 0, go directly to START.
- Beat rules:
  - A beat with count ≥ H+1 emits an output. Every row therefore yields exactly N outputs for any N ≥ 1, including N ≤ H.
  - o_eor is set on the final output of the row.
  - o_eof = that beat's registered (eor && eof). An eof without eor is dropped.
- Pipeline: three register stages (products, partial-sum tree, shift/saturate/output register). Valid and flags travel alongside the data.

## Timing
- Reset values: o_vld=0, o_eor=0, o_eof=0, o_data=0, o_rdy=0 during reset and 1 in the cycle after. Window, count and skid buffer are cleared; FSM = START.
- Reset mid-row: all in-flight data is discarded. The next accepted pixel is treated as x0 of a new row.
- Advance: the whole PE advances when !o_vld || i_rdy; otherwise it holds.
- Hold rule: while o_vld && !i_rdy, o_data, o_eor and o_eof are held stable.
- Latency: an emitting beat taken at edge t gives o_vld high after edge t+3 (no stall).
- Throughput: 1 pixel/cycle in STREAM.
- Row gap: H cycles of FLUSH per row. The next row's x0 is accepted the cycle after the last FLUSH beat.
- Simultaneous events: eor on the first pixel (N=1) goes START→FLUSH. An input stall during STREAM holds the window without emitting.

## Configuration
- ROW_PE_EDGE_REPLICATE_EN:
  - Defined: left pad = x0, right pad = x[N−1] (registered at eor).
  - Undefined: both pads = 0 (zero padding).

## Test plan
- Defaults, zero pad, i_rdy=1, row [4,8,12,16] with eor: outputs 4, 8, 12, 11; o_eor only on 11. With replicate: 5, 8, 12, 15.
- Single-pixel row [100] with eor+eof: zero pad gives 50 with o_eor=o_eof=1; replicate gives 100.
- WEIGHTS={−1,4,−1}, NORM_SHIFT=1, zero pad, row [0,255,0]: outputs 0, 255, 0 (saturation at both bounds).
- 32-pixel ramp row with random i_vld gaps and i_rdy toggling 1010 plus 5-cycle stalls: output sequence equals the golden model. o_data is stable while stalled. No loss or duplication; exactly 32 outputs.
- Pixel with eof=1, eor=0 mid-row: no o_eof is produced and the row continues normally.
- i_rst asserted after 2 pixels of a row, then row [4,8,12,16] is sent: o_vld=0 after reset; outputs match the first scenario exactly.
